// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared types and constants for the fixed-weight pattern generator
package weight_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int W_MAX = 8;
  localparam int IDX_W = 7;
  localparam int TZ_W  = 4;

endpackage

// File: rtl/weight_next.sv
// rtl/weight_next.sv - next-larger value of equal popcount, plus trailing-zero count
module weight_next
  import weight_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    pat_i,
  output logic [W-1:0]    next_o,
  output logic [TZ_W-1:0] tz_o
);

  logic [W-1:0] low_bit;
  logic [W-1:0] ripple;

  assign low_bit = pat_i & (-pat_i);
  assign ripple  = pat_i + low_bit;

  // Scan from the top so the lowest set bit wins; an all-zero input reports W.
  always_comb begin
    tz_o = TZ_W'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (pat_i[i]) tz_o = TZ_W'(i);
    end
  end

  // Shift replaces the divide by low_bit: low_bit is always 1 << tz.
  assign next_o = ((ripple ^ pat_i) >> (tz_o + TZ_W'(2))) | ripple;

endmodule

// File: rtl/weight_pattern_gen.sv
// rtl/weight_pattern_gen.sv - streams every W-bit value of a requested popcount in ascending order
module weight_pattern_gen
  import weight_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [3:0]       req_weight,
  output logic             req_ready,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [W-1:0]     pat_data,
  output logic             pat_last,
  output logic [IDX_W-1:0] pat_idx,
  output logic             req_err
);

  localparam logic [3:0] W4 = 4'(W);

  state_t           state_q;
  logic [3:0]       k_q;
  logic [W-1:0]     data_q;
  logic [W-1:0]     data_d;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             err_q;
  logic [TZ_W-1:0]  tz;

  function automatic logic [W-1:0] low_ones(input logic [3:0] k);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = (i < int'(k));
    return v;
  endfunction

  weight_next #(.W(W)) u_next (
    .pat_i  (data_q),
    .next_o (data_d),
    .tz_o   (tz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_weight > W4) begin
              err_q <= 1'b1;
            end else begin
              state_q <= EMIT;
              k_q     <= req_weight;
              data_q  <= low_ones(req_weight);
              idx_q   <= '0;
              valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (pat_ready) begin
            if (pat_last) begin
              state_q <= IDLE;
              data_q  <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
            end else begin
              data_q <= data_d;
              idx_q  <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The largest value of weight k is k ones packed at the top, i.e. exactly W-k trailing zeros.
  assign pat_last  = valid_q && (({1'b0, tz} + {1'b0, k_q}) == 5'(W));
  assign req_ready = (state_q == IDLE);
  assign pat_valid = valid_q;
  assign pat_data  = data_q;
  assign pat_idx   = idx_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// tb/tb_weight_pattern_gen.sv - scoreboard bench for weight_pattern_gen
module tb_weight_pattern_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [3:0]   req_weight = 4'd0;
  logic         req_ready;
  logic         pat_valid;
  logic         pat_ready = 1'b1;
  logic [W-1:0] pat_data;
  logic         pat_last;
  logic [6:0]   pat_idx;
  logic         req_err;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cur_k = 0;
  int   req_pops = 0;
  int   err_pulses = 0;
  bit   bp_en = 1'b0;
  logic [7:0] prev_data;

  weight_pattern_gen #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_weight (req_weight),
    .req_ready  (req_ready),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .pat_last   (pat_last),
    .pat_idx    (pat_idx),
    .req_err    (req_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // Reference: enumerate all W-bit values, keep those of popcount k in ascending order.
  task automatic push_expected(input int k);
    exp_t tmp[$];
    exp_t e;
    for (int v = 0; v < (1 << W); v++) begin
      if ($countones(v) == k) begin
        e.data = 8'(v);
        e.last = 1'b0;
        e.idx  = tmp.size();
        tmp.push_back(e);
      end
    end
    if (tmp.size() > 0) tmp[tmp.size() - 1].last = 1'b1;
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    pat_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (req_err) err_pulses++;

  logic       prev_stall = 1'b0;
  logic       prev_hs_nl = 1'b0;
  logic       prev_hs_last = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  logic [6:0] held_idx;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_hs_nl   = 1'b0;
      prev_hs_last = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", pat_valid, 1'b1);
        check("stall_data", pat_data, held_data);
        check("stall_last", pat_last, held_last);
        check("stall_idx", pat_idx, held_idx);
      end
      if (prev_hs_nl) check("no_bubble_valid", pat_valid, 1'b1);
      if (prev_hs_last) begin
        check("post_last_req_ready", req_ready, 1'b1);
        check("post_last_pat_valid", pat_valid, 1'b0);
      end
      prev_stall   = pat_valid && !pat_ready;
      held_data    = pat_data;
      held_last    = pat_last;
      held_idx     = pat_idx;
      prev_hs_nl   = 1'b0;
      prev_hs_last = 1'b0;
      if (pat_valid && pat_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pattern actual=%0h expected=none", pat_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pat_data", pat_data, e.data);
          check("pat_last", pat_last, e.last);
          check("pat_idx", pat_idx, e.idx);
          check("popcount", $countones(pat_data), cur_k);
          if (req_pops > 0) check("ascending", pat_data > prev_data, 1'b1);
          if (e.idx == 0) check("first_latency", cyc, acc_cyc);
        end
        prev_data    = pat_data;
        req_pops++;
        prev_hs_nl   = !pat_last;
        prev_hs_last = pat_last;
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_pat_valid"}, pat_valid, 1'b0);
    check({tag, "_pat_data"}, pat_data, 8'h00);
    check({tag, "_pat_last"}, pat_last, 1'b0);
    check({tag, "_pat_idx"}, pat_idx, 7'd0);
    check({tag, "_req_err"}, req_err, 1'b0);
  endtask

  task automatic do_req(input int k);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_pops = 0;
    cur_k    = k;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_weight = 4'(k);
    @(negedge clk);
    acc_cyc = cyc + 1;
    if (k <= W) push_expected(k);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int e0;
    int k;
    int n;
    #1;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    do_req(2);
    wait_done();
    check("w2_count", req_pops, binom(W, 2));

    do_req(0);
    wait_done();
    check("w0_count", req_pops, 1);
    do_req(8);
    wait_done();
    check("w8_count", req_pops, 1);

    e0 = err_pulses;
    do_req(9);
    check("w9_err", req_err, 1'b1);
    check("w9_ready", req_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("w9_no_valid", pat_valid, 1'b0);
      check("w9_ready_hold", req_ready, 1'b1);
    end
    check("w9_err_pulses", err_pulses - e0, 1);

    bp_en = 1'b1;
    e0 = err_pulses;
    do_req(4);
    repeat (3) @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_weight = 4'd9;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done();
    check("w4_count", req_pops, binom(W, 4));
    check("w4_no_err", err_pulses - e0, 0);
    bp_en = 1'b0;

    do_req(3);
    n = 0;
    while (req_pops < 6 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("w3_reached_idx5", req_pops >= 6, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_no_valid", pat_valid, 1'b0);
    end
    do_req(1);
    wait_done();
    check("w1_count", req_pops, binom(W, 1));

    bp_en = 1'b1;
    repeat (4) begin
      k = $urandom_range(0, 9);
      do_req(k);
      wait_done();
      if (k <= W) check("rand_count", req_pops, binom(W, k));
    end
    bp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_pattern_gen.md
WEIGHT_PATTERN_GEN -- requirements
Module: weight_pattern_gen

Interface
REQ-001 Parameter: W, default 8, pattern width in bits; supported range 2..8.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_weight  input  4  requested number of set bits, 0..15.
REQ-006 Port: req_ready  output  1  block can accept a request.
REQ-007 Port: pat_valid  output  1  pat_data holds a valid pattern.
REQ-008 Port: pat_ready  input  1  consumer accepts the pattern.
REQ-009 Port: pat_data  output  W  pattern with exactly req_weight ones.
REQ-010 Port: pat_last  output  1  final pattern of the current request.
REQ-011 Port: pat_idx  output  7  zero-based index of the pattern within the request.
REQ-012 Port: req_err  output  1  one-cycle pulse when the request is rejected.

Function
REQ-013 The block SHALL emit every W-bit value whose popcount equals the accepted weight k, each exactly once, in strictly ascending numeric order.
REQ-014 The FSM SHALL have two states.
  - IDLE: req_ready=1.
  - EMIT: req_ready=0.
REQ-015 A request SHALL be accepted on a cycle where req_valid && req_ready; k is latched on that edge.
REQ-016 If accepted k <= W, the FSM SHALL move to EMIT with pat_data = (1<<k)-1, pat_idx=0, and pat_valid=1 on the following cycle.
  - This gives a first-pattern latency of 1 cycle.
REQ-017 If accepted k > W, the block SHALL stay in IDLE and pulse req_err for exactly the cycle after acceptance; pat_valid stays 0.
REQ-018 While pat_valid && !pat_ready, pat_data, pat_last and pat_idx SHALL hold stable.
REQ-019 On a handshake (pat_valid && pat_ready) with pat_last=0, the block SHALL advance on the next cycle, with no bubble.
  - pat_data gets the next-larger value of equal popcount: c=p&-p; r=p+c; next=(((r^p)>>2)/c)|r, computed without a divider as ((r^p)>>(tz(p)+2))|r, where tz is trailing zeros.
  - pat_idx increments.
REQ-020 pat_last SHALL be 1 exactly when pat_data equals k ones packed in the MSBs (including k=0 -> 0x00 and k=W -> all ones); each of those requests emits one pattern.
REQ-021 A handshake with pat_last=1 SHALL return the FSM to IDLE; req_ready=1 on the next cycle and pat_valid=0 unless a new request is accepted.
REQ-022 A new request SHALL not be accepted in the same cycle as the final handshake.
REQ-023 The pattern count per request SHALL equal C(W,k); for W=8 the maximum is 70, which fits pat_idx.
REQ-024 req_weight and req_valid SHALL be ignored while in EMIT.

Reset
REQ-025 When rst is asserted, the block SHALL immediately force: state=IDLE, req_ready=1, pat_valid=0, pat_data=0, pat_last=0, pat_idx=0, req_err=0.
REQ-026 Reset mid-stream SHALL abort the request with no further patterns; the first request after deassertion behaves as from power-up.

Structure
REQ-027 A shared package weight_pkg SHALL hold the FSM state enum (IDLE, EMIT) and the constants W_MAX=8 and IDX_W=7.
REQ-028 A combinational sub-module weight_next SHALL compute the next pattern and the trailing-zero count.
  - The FSM, registers and handshakes SHALL reside in weight_pattern_gen.

Verification
REQ-029 Weight 2, pat_ready=1: the bench SHALL check the following.
  - 28 patterns: 0x03, 0x05, 0x06, 0x09, ..., 0xC0.
  - pat_last only on 0xC0, pat_idx 0..27.
  - One pattern per cycle, first pattern 1 cycle after acceptance.
REQ-030 Weights 0 and 8: the bench SHALL check one pattern each (0x00 and 0xFF respectively), with pat_last=1 and pat_idx=0.
REQ-031 Weight 9: the bench SHALL check that req_err pulses for 1 cycle, pat_valid never asserts, and req_ready stays 1.
REQ-032 Weight 4 with random pat_ready backpressure: the bench SHALL check 70 patterns, outputs stable while stalled, an ascending order, and popcount=4 on each.
REQ-033 Weight 3 with rst asserted after pat_idx=5: the bench SHALL check that outputs clear immediately; then a weight-1 request yields 0x01, 0x02, ..., 0x80 with last on 0x80.
